// File: rtl/array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : array_pkg
// Description : Definitions shared by the 4x4 output-stationary PE array and
//               its output collector. It holds the default element format and
//               array geometry, the collector state encoding and a clog2
//               helper. Optional build macro consumed by importers:
//               OUT_COLLECT_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package array_pkg;

    // Default element format and array geometry.
    localparam int c_width      = 16;  // bits per element, signed fixed point
    localparam int c_decimal    = 8;   // fractional bits
    localparam int c_rows       = 4;   // PE rows = result rows per drain
    localparam int c_cols       = 4;   // PE columns = elements per row
    localparam int c_fifo_depth = 8;   // result-row FIFO entries

    // Collector FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } collector_state_t;

    // Bits needed to index 'value' items. The result is never below 1, so a
    // degenerate size still yields a legal vector width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : out_row_fifo
// Description : Synchronous first-word-fall-through FIFO for result rows.
//               pop_data always shows the head entry. A push into a full FIFO
//               is accepted only when a pop happens in the same cycle.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   push      in   write request
//   push_data in   DATA_W  write data
//   full      out  FIFO holds DEPTH entries
//   pop       in   read request; ignored while empty
//   pop_data  out  DATA_W  head entry
//   empty     out  FIFO holds no entries
// Revision    : 1.0 - initial release
// ============================================================================
module out_row_fifo
    import array_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty
);

    localparam int c_ptr_w = clog2(DEPTH);
    localparam int c_cnt_w = clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted.
    assign w_do_push = push && ((r_count != c_cnt_full) || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign full     = (r_count == c_cnt_full);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/array_out_collector.sv
`default_nettype none
// ============================================================================
// Module      : array_out_collector
// Description : Drains the PE array outs bus. It removes the per-column
//               diagonal skew, optionally applies ReLU and buffers aligned
//               rows in a FWFT FIFO that is read over a valid/ready handshake.
//               Build macro OUT_COLLECT_RELU_EN zeroes negative elements
//               before the FIFO push.
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   drain_start in   one-cycle pulse; results shift out from the next cycle
//   outs_in     in   COLS*WIDTH  array outs, column c at [c*WIDTH +: WIDTH]
//   out_valid   out  head row available
//   out_ready   in   consumer accepts head row
//   out_data    out  COLS*WIDTH  aligned row, same packing as outs_in
//   out_row_idx out  clog2(ROWS) row index within the drain
//   busy        out  drain in progress or rows still buffered
//   overflow    out  sticky, a row was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module array_out_collector
    import array_pkg::*;
#(
    parameter int WIDTH      = c_width,
    parameter int DECIMAL    = c_decimal,
    parameter int ROWS       = c_rows,
    parameter int COLS       = c_cols,
    parameter int FIFO_DEPTH = c_fifo_depth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drain_start,
    input  logic [COLS*WIDTH-1:0]   outs_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*WIDTH-1:0]   out_data,
    output logic [clog2(ROWS)-1:0]  out_row_idx,
    output logic                    busy,
    output logic                    overflow
);

    localparam int c_idx_w  = clog2(ROWS);
    localparam int c_row_w  = COLS * WIDTH;
    localparam int c_cnt_w  = clog2((ROWS > COLS) ? ROWS : COLS);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'((COLS > 1) ? COLS - 2 : 0);
    localparam logic [c_cnt_w-1:0] c_row_last  = c_cnt_w'(ROWS - 1);

    // Elements are carried bit-exact in their fixed-point format; the
    // fractional position matters only to the consumer. An out-of-range
    // DECIMAL elaborates this empty marker block.
    if ((DECIMAL < 0) || (DECIMAL >= WIDTH)) begin : g_decimal_out_of_range
    end

    // ------------------------------------------------------------------
    // Deskew: column c is delayed by COLS-1-c cycles. Each element of a
    // row then reaches the FIFO input in the same cycle.
    // ------------------------------------------------------------------
    logic [c_row_w-1:0] w_row;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int c_stages = COLS - 1 - c;
        logic [WIDTH-1:0] w_aligned;

        if (c_stages == 0) begin : g_pass
            assign w_aligned = outs_in[c*WIDTH +: WIDTH];
        end else begin : g_dly
            logic [WIDTH-1:0] r_pipe [c_stages];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < c_stages; s++) begin
                        r_pipe[s] <= '0;
                    end
                end else begin
                    r_pipe[0] <= outs_in[c*WIDTH +: WIDTH];
                    for (int s = 1; s < c_stages; s++) begin
                        r_pipe[s] <= r_pipe[s-1];
                    end
                end
            end

            assign w_aligned = r_pipe[c_stages-1];
        end

`ifdef OUT_COLLECT_RELU_EN
        // A negative element is replaced by zero. This is combinational,
        // so it adds no latency.
        assign w_row[c*WIDTH +: WIDTH] = w_aligned[WIDTH-1] ? '0 : w_aligned;
`else
        assign w_row[c*WIDTH +: WIDTH] = w_aligned;
`endif
    end

    // ------------------------------------------------------------------
    // Drain sequencer: WAIT covers the deskew fill (COLS-1 cycles). CAPT
    // pushes one aligned row per cycle for ROWS cycles.
    // ------------------------------------------------------------------
    collector_state_t   r_state;
    collector_state_t   w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (drain_start) begin
                    w_cnt_nxt = '0;
                    if (COLS == 1) begin
                        w_state_nxt = CAPT;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == c_wait_last) begin
                    w_state_nxt = CAPT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            CAPT: begin
                w_push = 1'b1;
                if (r_cnt == c_row_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row FIFO. Each entry holds the row index above the row data.
    // ------------------------------------------------------------------
    logic [c_idx_w+c_row_w-1:0] w_push_data;
    logic [c_idx_w+c_row_w-1:0] w_head;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;
    logic                       w_drop;
    logic                       r_overflow;

    assign w_push_data = {c_idx_w'(r_cnt), w_row};
    assign w_pop       = out_ready && !w_empty;
    // The array cannot be stalled. A row that finds the FIFO full with no
    // simultaneous pop is lost.
    assign w_drop      = w_push && w_full && !w_pop;

    out_row_fifo #(
        .DATA_W (c_idx_w + c_row_w),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .full      (w_full),
        .pop       (w_pop),
        .pop_data  (w_head),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_valid   = !w_empty;
    assign out_data    = w_head[c_row_w-1:0];
    assign out_row_idx = w_head[c_idx_w+c_row_w-1:c_row_w];
    assign busy        = (r_state != IDLE) || !w_empty;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_array_out_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_out_collector
// Description : Directed self-checking bench for array_out_collector with a
//               FIFO depth of 4. Expected rows go into a queue when a drain
//               is started and are matched against rows the DUT hands over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_array_out_collector;

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] data;
    } row_t;

    logic        clk;
    logic        rst;
    logic        drain_start;
    logic [63:0] outs_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_row_idx;
    logic        busy;
    logic        overflow;

    int   checks;
    int   errors;
    int   dk;        // cycles since the current drain_start, -1 when idle
    int   pat;       // data pattern of the drain being driven
    row_t q[$];
    logic        hold_pending;
    logic [65:0] hold_val;

    array_out_collector #(
        .WIDTH      (16),
        .DECIMAL    (8),
        .ROWS       (4),
        .COLS       (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .drain_start (drain_start),
        .outs_in     (outs_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row_idx (out_row_idx),
        .busy        (busy),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] elem(input int p, input int r, input int c);
        if (p == 99) begin
            return (c % 2 == 0) ? 16'hFF00 : 16'h0080;
        end
        return 16'(16'h0100 * (r + 1) + c + 16'h0010 * p);
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rows(input int p);
        row_t        it;
        logic [15:0] e;
        for (int r = 0; r < 4; r++) begin
            it.idx  = 2'(r);
            it.data = '0;
            for (int c = 0; c < 4; c++) begin
                e = elem(p, r, c);
`ifdef OUT_COLLECT_RELU_EN
                if (e[15]) e = 16'h0000;
`endif
                it.data[c*16 +: 16] = e;
            end
            q.push_back(it);
        end
    endtask

    // One clock: drive outs_in, check the current outputs, advance to the
    // next negedge.
    task automatic step();
        row_t exp_row;
        int   r;
        for (int c = 0; c < 4; c++) begin
            r = dk - 1 - c;
            if (dk >= 0 && r >= 0 && r < 4) outs_in[c*16 +: 16] = elem(pat, r, c);
            else                            outs_in[c*16 +: 16] = 16'hBAD0 | 16'(c);
        end
        if (hold_pending) begin
            chk("hold_valid", 66'(out_valid), 66'd1);
            chk("hold_data", {out_row_idx, out_data}, hold_val);
        end
        hold_pending = out_valid && !out_ready;
        hold_val     = {out_row_idx, out_data};
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed row %0h idx %0d, expected no row", out_data, out_row_idx);
            end
            if (q.size() > 0) begin
                exp_row = q.pop_front();
                chk("sb_row", {out_row_idx, out_data}, {exp_row.idx, exp_row.data});
            end
        end
        @(negedge clk);
        drain_start = 1'b0;
        if (dk >= 0) dk++;
        if (dk > 9) dk = -1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic start_drain(input int p, input bit expect_rows);
        pat         = p;
        dk          = 0;
        drain_start = 1'b1;
        if (expect_rows) push_rows(p);
        step();
    endtask

    task automatic pulse();
        drain_start = 1'b1;
        step();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        dk           = -1;
        pat          = 0;
        hold_pending = 1'b0;
        hold_val     = '0;
        rst          = 1'b0;
        drain_start  = 1'b0;
        out_ready    = 1'b0;
        outs_in      = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", 66'(out_valid), 66'd0);
        chk("rst_busy", 66'(busy), 66'd0);
        chk("rst_overflow", 66'(overflow), 66'd0);
        chk("rst_data", {out_row_idx, out_data}, 66'd0);
        rst = 1'b1;
        run(2);

        // Single drain, consumer always ready; check first-row latency
        out_ready = 1'b1;
        start_drain(0, 1'b1);
        chk("t1_busy", 66'(busy), 66'd1);
        run(3);
        chk("t1_valid_early", 66'(out_valid), 66'd0);
        step();
        chk("t1_valid_first", 66'(out_valid), 66'd1);
        chk("t1_row0", {out_row_idx, out_data}, {2'd0, 64'h0103_0102_0101_0100});
        run(8);
        chk("t1_done", 66'(q.size()), 66'd0);
        chk("t1_idle", 66'(busy), 66'd0);

        // Backpressure through a whole drain
        out_ready = 1'b0;
        start_drain(1, 1'b1);
        run(10);
        chk("t2_valid", 66'(out_valid), 66'd1);
        chk("t2_overflow", 66'(overflow), 66'd0);
        out_ready = 1'b1;
        run(6);
        chk("t2_done", 66'(q.size()), 66'd0);

        // Extra drain_start pulses in WAIT, in CAPT and on the last CAPT cycle
        start_drain(2, 1'b1);
        step();
        pulse();
        run(2);
        pulse();
        step();
        pulse();
        run(16);
        chk("t4_done", 66'(q.size()), 66'd0);
        chk("t4_idle", 66'(busy), 66'd0);

        // ReLU
        start_drain(99, 1'b1);
        run(12);
        chk("t5_done", 66'(q.size()), 66'd0);

        // Full FIFO with push and pop in the same cycle: no loss
        out_ready = 1'b0;
        start_drain(5, 1'b1);
        run(10);
        start_drain(6, 1'b1);
        run(3);
        out_ready = 1'b1;
        run(12);
        chk("tfull_overflow", 66'(overflow), 66'd0);
        chk("tfull_done", 66'(q.size()), 66'd0);

        // Overflow: second drain dropped, first drain kept intact
        out_ready = 1'b0;
        start_drain(3, 1'b1);
        run(10);
        chk("t3_overflow_pre", 66'(overflow), 66'd0);
        start_drain(4, 1'b0);
        run(10);
        chk("t3_overflow", 66'(overflow), 66'd1);
        out_ready = 1'b1;
        run(8);
        chk("t3_done", 66'(q.size()), 66'd0);
        chk("t3_sticky", 66'(overflow), 66'd1);

        // Asynchronous reset in the middle of CAPT
        out_ready = 1'b0;
        start_drain(7, 1'b0);
        run(6);
        chk("t6_valid_pre", 66'(out_valid), 66'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", 66'(out_valid), 66'd0);
        chk("t6_busy", 66'(busy), 66'd0);
        chk("t6_overflow", 66'(overflow), 66'd0);
        chk("t6_data", {out_row_idx, out_data}, 66'd0);
        @(negedge clk);
        rst          = 1'b1;
        dk           = -1;
        hold_pending = 1'b0;
        out_ready    = 1'b1;
        run(2);
        start_drain(8, 1'b1);
        run(14);
        chk("t6_done", 66'(q.size()), 66'd0);
        chk("t6_overflow_after", 66'(overflow), 66'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
